aes_block: RTL and testbench

- One registered AES encryption round without key mixing: SubBytes, then ShiftRows, then MixColumns.
- Applied to a 128-bit state every clock cycle.
- Sits in the AES datapath as the reusable round core. AddRoundKey and key expansion are handled outside this block.
- Fully pipelined: a new state is accepted every cycle, and the result appears one cycle later.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 12 +
 rtl/aes_block.sv | 69 ++++++
 tb/tb_aes_block.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round core.
// Holds the forward S-box table, the GF(2^8) xtime helper, the row-major
// byte-position helper and the 128-bit state type.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x (0x02) in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // LSB position of byte s[r][c]; row 0 column 0 occupies the top byte.
  function automatic int byte_lsb(input int r, input int c);
    return 120 - 8 * (4 * r + c);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational lookup.
// Ports: i_byte - input byte; o_byte - substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_block.sv
// One registered AES round without key mixing:
// SubBytes -> ShiftRows -> MixColumns, one new state per cycle, 1-cycle latency.
// Ports:
//   clock   - rising-edge clock for the output register
//   reset_n - asynchronous active-low reset, clears out
//   in      - 128-bit input state, row-major (top byte = s[0][0])
//   out     - registered round result, same layout
module aes_block
  import aes_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  aes_state_t in,
  output aes_state_t out
);

  logic [7:0] w_sb  [4][4];
  logic [7:0] w_sr  [4][4];
  logic [7:0] w_mix [4][4];
  aes_state_t w_next;
  aes_state_t r_out;

  genvar r, c;
  generate
    for (r = 0; r < 4; r++) begin : g_row
      for (c = 0; c < 4; c++) begin : g_col
        localparam int LSB = byte_lsb(r, c);

        aes_sbox u_sbox (
          .i_byte (in[LSB +: 8]),
          .o_byte (w_sb[r][c])
        );

        // Row r rotates left by r: destination column c takes source column c+r.
        assign w_sr[r][c] = w_sb[r][(c + r) % 4];

        assign w_next[LSB +: 8] = w_mix[r][c];
      end
    end

    for (c = 0; c < 4; c++) begin : g_mix
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      logic [7:0] w_x0, w_x1, w_x2, w_x3;

      assign w_a0 = w_sr[0][c];
      assign w_a1 = w_sr[1][c];
      assign w_a2 = w_sr[2][c];
      assign w_a3 = w_sr[3][c];
      assign w_x0 = xtime(w_a0);
      assign w_x1 = xtime(w_a1);
      assign w_x2 = xtime(w_a2);
      assign w_x3 = xtime(w_a3);

      // 3a = xtime(a) ^ a
      assign w_mix[0][c] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
      assign w_mix[1][c] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
      assign w_mix[2][c] = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
      assign w_mix[3][c] = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_out <= '0;
    else          r_out <= w_next;
  end

  assign out = r_out;

endmodule

// File: tb/tb_aes_block.sv
module tb_aes_block;

  logic         clock;
  logic         reset_n;
  logic [127:0] tb_in;
  logic [127:0] tb_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];

  aes_block dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (tb_in),
    .out     (tb_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // General GF(2^8) multiply, shift-and-add with reduction by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int k = 1; k < 256; k++)
        if (v != 0 && gf_mul(8'(v), 8'(k)) == 8'h01) inv = 8'(k);
      sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] x);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = sbox_tab[x[127 - 8*(4*r + c) -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = s[r][(c + r) % 4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        // Row r of the circulant matrix is (02 03 01 01) rotated right by r.
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          int d = (k - r + 4) % 4;
          logic [7:0] coef = (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
          acc = acc ^ gf_mul(coef, t[k][c]);
        end
        y[127 - 8*(4*r + c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present v for the next edge, then compare one step after that edge.
  task automatic step(input string tag, input logic [127:0] v);
    tb_in = v;
    @(posedge clock);
    #1;
    check(tag, tb_out, ref_round(v));
  endtask

  logic [127:0] v;

  initial begin
    build_sbox();
    reset_n = 1'b1;
    tb_in   = {16{8'hFF}};

    // Load something nonzero so the asynchronous clear is observable.
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_async", tb_out, 128'h0);
    @(posedge clock);
    #1;
    check("rst_hold", tb_out, 128'h0);
    reset_n = 1'b1;
    #2;
    check("rst_release_no_edge", tb_out, 128'h0);
    @(posedge clock);
    #1;
    check("first_after_rst", tb_out, {16{8'h16}});

    tb_in = 128'h0;
    @(posedge clock);
    #1;
    check("zero_state", tb_out, {16{8'h63}});

    tb_in = 128'h9F9F9F9F_82828282_50505050_68686868;
    @(posedge clock);
    #1;
    check("mixcol_const", tb_out, 128'h8E8E8E8E_4D4D4D4D_A1A1A1A1_BCBCBCBC);

    step("shiftrows_orient", 128'h00010203_04050607_08090A0B_0C0D0E0F);

    step("stream0", 128'h544F4E20776E69546F656E772020656F);
    step("stream1", 128'h5473206768204B20616D754674796E75);
    step("stream2", 128'h5473206768204B20616D754574796E75);
    step("stream3", 128'h5473206768204B20616D754074796E75);
    step("stream4", 128'h5473206768204B20616D754A74796E75);

    for (int i = 0; i < 24; i++) step("rand_stream", rand128());

    // Mid-stream reset pulse between edges.
    tb_in   = rand128();
    reset_n = 1'b0;
    #1;
    check("midrst_async", tb_out, 128'h0);
    @(posedge clock);
    #1;
    check("midrst_hold", tb_out, 128'h0);
    reset_n = 1'b1;
    v = rand128();
    step("midrst_resume", v);

    for (int i = 0; i < 8; i++) step("rand_after_rst", rand128());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
